// File: rtl/counter_game_pkg.sv
// Shared encodings for the counter game: counting modes, game-over result
// codes and the round scheduler state enum.
package counter_game_pkg;

  localparam logic [1:0] COUNT_UP_BY_1   = 2'b00;
  localparam logic [1:0] COUNT_UP_BY_2   = 2'b01;
  localparam logic [1:0] COUNT_DOWN_BY_1 = 2'b10;
  localparam logic [1:0] COUNT_DOWN_BY_2 = 2'b11;

  localparam logic [1:0] WHO_MAX  = 2'b10;
  localparam logic [1:0] WHO_ZERO = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/counter_game_scheduler_rr_arbiter2.sv
// Two-requester round-robin picker. The priority pointer flips to the player
// that did not own the round when advance is pulsed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic [1:0] owner,
  output logic [1:0] gnt
);

  // prio_q = 1 means player 1 wins a tie; reset gives player 0 the tie.
  logic prio_q;
  logic prio_d;

  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      prio_d = (owner == 2'b01);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/counter_game_scheduler.sv
// Round scheduler over a shared multi-mode counter: grants rounds to two
// players round-robin, loads their mode/value, scores results, ends matches.
module counter_game_scheduler
  import counter_game_pkg::*;
#(
  parameter int DATA_W        = 5,
  parameter int SCORE_W       = 2,
  parameter int WINS_TO_MATCH = 3,
  parameter int ROUND_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        p0_mode,
  input  logic [1:0]        p1_mode,
  input  logic [DATA_W-1:0] p0_init_val,
  input  logic [DATA_W-1:0] p1_init_val,
  input  logic              cnt_gameover,
  input  logic [1:0]        cnt_who,
  output logic [1:0]        cnt_mode,
  output logic              cnt_init,
  output logic [DATA_W-1:0] cnt_init_val,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic              round_timeout,
  output logic              match_over,
  output logic [1:0]        match_winner,
  output logic [2:0]        state_dbg
);

  localparam int TIMER_W = (ROUND_TIMEOUT > 2) ? $clog2(ROUND_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(WINS_TO_MATCH);

  // Handshake: req is a level request a player holds until served; the
  // acknowledge is grant together with the single cnt_init cycle of LOAD.
  sched_state_t        state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [1:0]          cnt_mode_q, cnt_mode_d;
  logic                cnt_init_q, cnt_init_d;
  logic [DATA_W-1:0]   cnt_init_val_q, cnt_init_val_d;
  logic [SCORE_W-1:0]  score0_q, score0_d;
  logic [SCORE_W-1:0]  score1_q, score1_d;
  logic                round_timeout_q, round_timeout_d;
  logic                match_over_q, match_over_d;
  logic [1:0]          match_winner_q, match_winner_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                advance;
  logic                round_end;
  logic [1:0]          arb_gnt;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .owner   (grant_q),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    busy_d          = busy_q;
    cnt_mode_d      = cnt_mode_q;
    cnt_init_d      = 1'b0;
    cnt_init_val_d  = cnt_init_val_q;
    score0_d        = score0_q;
    score1_d        = score1_q;
    round_timeout_d = 1'b0;
    match_over_d    = match_over_q;
    match_winner_d  = match_winner_q;
    timer_d         = timer_q;
    advance         = 1'b0;
    round_end       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d        = ST_LOAD;
          grant_d        = arb_gnt;
          busy_d         = 1'b1;
          cnt_init_d     = 1'b1;
          cnt_mode_d     = arb_gnt[1] ? p1_mode : p0_mode;
          cnt_init_val_d = arb_gnt[1] ? p1_init_val : p0_init_val;
        end
      end

      ST_LOAD: begin
        state_d = ST_RUN;
        timer_d = '0;
      end

      ST_RUN: begin
        timer_d = timer_q + TIMER_W'(1);
        if (cnt_gameover) begin
          round_end = 1'b1;
          // WHO_MAX credits the round owner, WHO_ZERO its opponent.
          if (cnt_who == WHO_MAX) begin
            if (grant_q[1]) score1_d = sat_inc(score1_q);
            else            score0_d = sat_inc(score0_q);
          end else if (cnt_who == WHO_ZERO) begin
            if (grant_q[1]) score0_d = sat_inc(score0_q);
            else            score1_d = sat_inc(score1_q);
          end
        end else if (timer_q == TIMER_LAST) begin
          round_end       = 1'b1;
          round_timeout_d = 1'b1;
        end
        if (round_end) begin
          state_d        = ST_SETTLE;
          cnt_mode_d     = COUNT_UP_BY_1;
          cnt_init_val_d = '0;
        end
      end

      ST_SETTLE: begin
        advance = 1'b1;
        grant_d = 2'b00;
        busy_d  = 1'b0;
        if ((score0_q == WIN_SCORE) || (score1_q == WIN_SCORE)) begin
          state_d        = ST_DONE;
          match_over_d   = 1'b1;
          match_winner_d = {score1_q == WIN_SCORE, score0_q == WIN_SCORE};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (req == 2'b00) begin
          state_d        = ST_IDLE;
          score0_d       = '0;
          score1_d       = '0;
          match_over_d   = 1'b0;
          match_winner_d = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      grant_q         <= 2'b00;
      busy_q          <= 1'b0;
      cnt_mode_q      <= COUNT_UP_BY_1;
      cnt_init_q      <= 1'b0;
      cnt_init_val_q  <= '0;
      score0_q        <= '0;
      score1_q        <= '0;
      round_timeout_q <= 1'b0;
      match_over_q    <= 1'b0;
      match_winner_q  <= 2'b00;
      timer_q         <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      busy_q          <= busy_d;
      cnt_mode_q      <= cnt_mode_d;
      cnt_init_q      <= cnt_init_d;
      cnt_init_val_q  <= cnt_init_val_d;
      score0_q        <= score0_d;
      score1_q        <= score1_d;
      round_timeout_q <= round_timeout_d;
      match_over_q    <= match_over_d;
      match_winner_q  <= match_winner_d;
      timer_q         <= timer_d;
    end
  end

  assign cnt_mode      = cnt_mode_q;
  assign cnt_init      = cnt_init_q;
  assign cnt_init_val  = cnt_init_val_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign score0        = score0_q;
  assign score1        = score1_q;
  assign round_timeout = round_timeout_q;
  assign match_over    = match_over_q;
  assign match_winner  = match_winner_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_counter_game_scheduler.sv
// Bench for counter_game_scheduler: the counter is stubbed, rounds are driven
// from a vector table, fixed corner sequences and a round-level random model.
module tb_counter_game_scheduler;
  import counter_game_pkg::*;

  localparam int DATA_W  = 5;
  localparam int SCORE_W = 2;
  localparam int WINS    = 3;
  localparam int TMO     = 64;

  logic              clk;
  logic              rst;
  logic [1:0]        req;
  logic [1:0]        p0_mode, p1_mode;
  logic [DATA_W-1:0] p0_init_val, p1_init_val;
  logic              cnt_gameover;
  logic [1:0]        cnt_who;
  logic [1:0]        cnt_mode;
  logic              cnt_init;
  logic [DATA_W-1:0] cnt_init_val;
  logic [1:0]        grant;
  logic              busy;
  logic [SCORE_W-1:0] score0, score1;
  logic              round_timeout;
  logic              match_over;
  logic [1:0]        match_winner;
  logic [2:0]        state_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  counter_game_scheduler #(
    .DATA_W(DATA_W), .SCORE_W(SCORE_W), .WINS_TO_MATCH(WINS), .ROUND_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .p0_mode(p0_mode), .p1_mode(p1_mode),
    .p0_init_val(p0_init_val), .p1_init_val(p1_init_val),
    .cnt_gameover(cnt_gameover), .cnt_who(cnt_who),
    .cnt_mode(cnt_mode), .cnt_init(cnt_init), .cnt_init_val(cnt_init_val),
    .grant(grant), .busy(busy), .score0(score0), .score1(score1),
    .round_timeout(round_timeout), .match_over(match_over),
    .match_winner(match_winner), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_init"}, cnt_init, 0);
    chk({tag, "_mode"}, cnt_mode, 0);
    chk({tag, "_val"}, cnt_init_val, 0);
    chk({tag, "_s0"}, score0, 0);
    chk({tag, "_s1"}, score1, 0);
    chk({tag, "_tmo"}, round_timeout, 0);
    chk({tag, "_mover"}, match_over, 0);
    chk({tag, "_mwin"}, match_winner, 0);
    chk({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req = 2'b00; p0_mode = 2'b00; p1_mode = 2'b00;
    p0_init_val = '0; p1_init_val = '0;
    cnt_gameover = 1'b0; cnt_who = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);
  endtask

  // driver: one full round from an IDLE negedge through SETTLE (and DONE exit)
  task automatic do_round(input logic [1:0] r, input logic [1:0] m0, input logic [1:0] m1,
                          input logic [4:0] v0, input logic [4:0] v1, input int len,
                          input bit go, input logic [1:0] who, input logic [1:0] e_gnt,
                          input logic [1:0] e_s0, input logic [1:0] e_s1, input bit e_done);
    logic [1:0] e_mode;
    logic [4:0] e_val;
    e_mode = e_gnt[1] ? m1 : m0;
    e_val  = e_gnt[1] ? v1 : v0;
    req = r; p0_mode = m0; p1_mode = m1; p0_init_val = v0; p1_init_val = v1;
    cnt_gameover = 1'b0; cnt_who = 2'b00;
    @(negedge clk);
    chk("load_grant", grant, e_gnt);
    chk("load_init", cnt_init, 1);
    chk("load_val", cnt_init_val, e_val);
    chk("load_mode", cnt_mode, e_mode);
    chk("load_busy", busy, 1);
    req = 2'b00;
    p0_mode = ~m0; p1_mode = ~m1; p0_init_val = ~v0; p1_init_val = ~v1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk("run_mode", cnt_mode, e_mode);
      chk("run_init", cnt_init, 0);
      chk("run_tmo", round_timeout, 0);
      if (go && i == len - 1) begin
        cnt_gameover = 1'b1;
        cnt_who = who;
      end
    end
    @(negedge clk);
    cnt_gameover = 1'b0; cnt_who = 2'b00;
    chk("settle_tmo", round_timeout, go ? 0 : 1);
    chk("settle_s0", score0, e_s0);
    chk("settle_s1", score1, e_s1);
    chk("settle_grant", grant, e_gnt);
    chk("settle_busy", busy, 1);
    chk("settle_mode", cnt_mode, 0);
    @(negedge clk);
    chk("post_grant", grant, 0);
    chk("post_busy", busy, 0);
    chk("post_tmo", round_timeout, 0);
    chk("post_mover", match_over, e_done);
    if (e_done) begin
      chk("done_winner", match_winner, (e_s0 == 2'(WINS)) ? 2'b01 : 2'b10);
      req = 2'b11;
      repeat (3) begin
        @(negedge clk);
        chk("done_hold", match_over, 1);
        chk("done_noload", cnt_init, 0);
        chk("done_s0", score0, e_s0);
        chk("done_s1", score1, e_s1);
      end
      req = 2'b00;
      @(negedge clk);
      chk("exit_mover", match_over, 0);
      chk("exit_s0", score0, 0);
      chk("exit_s1", score1, 0);
      chk("exit_state", state_dbg, ST_IDLE);
    end else begin
      chk("post_state", state_dbg, ST_IDLE);
    end
  endtask

  typedef struct {
    logic [1:0] r;
    logic [1:0] m0, m1;
    logic [4:0] v0, v1;
    int         len;
    bit         go;
    logic [1:0] who;
    logic [1:0] e_gnt;
    logic [1:0] e_s0, e_s1;
    bit         e_done;
  } vec_t;

  vec_t vecs[9];

  // round-level reference model state
  int m_prio;
  int sc[2];

  initial begin
    vecs[0] = '{2'b01, 2'b01, 2'b00, 5'd10, 5'd0,  3,  1, 2'b10, 2'b01, 2'd1, 2'd0, 0};
    vecs[1] = '{2'b10, 2'b00, 2'b10, 5'd0,  5'd7,  5,  1, 2'b01, 2'b10, 2'd2, 2'd0, 0};
    vecs[2] = '{2'b11, 2'b11, 2'b00, 5'd31, 5'd0,  64, 0, 2'b00, 2'b01, 2'd2, 2'd0, 0};
    vecs[3] = '{2'b11, 2'b00, 2'b11, 5'd1,  5'd20, 64, 1, 2'b10, 2'b10, 2'd2, 2'd1, 0};
    vecs[4] = '{2'b01, 2'b10, 2'b00, 5'd0,  5'd0,  1,  1, 2'b11, 2'b01, 2'd2, 2'd1, 0};
    vecs[5] = '{2'b01, 2'b00, 2'b00, 5'd5,  5'd0,  2,  1, 2'b10, 2'b01, 2'd3, 2'd1, 1};
    vecs[6] = '{2'b01, 2'b01, 2'b00, 5'd12, 5'd0,  4,  1, 2'b10, 2'b01, 2'd1, 2'd0, 0};
    vecs[7] = '{2'b01, 2'b11, 2'b00, 5'd17, 5'd0,  6,  1, 2'b10, 2'b01, 2'd2, 2'd0, 0};
    vecs[8] = '{2'b01, 2'b10, 2'b00, 5'd3,  5'd0,  2,  1, 2'b10, 2'b01, 2'd3, 2'd0, 1};

    reset_dut();
    for (int i = 0; i < 9; i++) begin
      do_round(vecs[i].r, vecs[i].m0, vecs[i].m1, vecs[i].v0, vecs[i].v1, vecs[i].len,
               vecs[i].go, vecs[i].who, vecs[i].e_gnt, vecs[i].e_s0, vecs[i].e_s1,
               vecs[i].e_done);
    end

    // req=11 held across four rounds: grants alternate from player 0
    reset_dut();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bit found;
      found = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (cnt_init) begin
          found = 1;
          break;
        end
      end
      chk("alt_load_seen", found, 1);
      chk("alt_grant", grant, (k % 2 == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      cnt_gameover = 1'b1; cnt_who = 2'b00;
      @(negedge clk);
      cnt_gameover = 1'b0;
    end
    req = 2'b00;
    @(negedge clk);
    chk("alt_state", state_dbg, ST_IDLE);
    chk("alt_s0", score0, 0);
    chk("alt_s1", score1, 0);

    // randomized rounds against the round-level model
    m_prio = 0; sc[0] = 0; sc[1] = 0;
    for (int n = 0; n < 30; n++) begin
      logic [1:0] r, m0, m1, who;
      logic [4:0] v0, v1;
      bit go, done;
      int len, pick;
      r   = 2'($urandom_range(1, 3));
      m0  = 2'($urandom_range(0, 3));
      m1  = 2'($urandom_range(0, 3));
      v0  = 5'($urandom_range(0, 31));
      v1  = 5'($urandom_range(0, 31));
      who = 2'($urandom_range(0, 3));
      go  = ($urandom_range(0, 3) != 0);
      len = go ? int'($urandom_range(1, TMO)) : TMO;
      pick = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : m_prio;
      if (go && who == 2'b10 && sc[pick] < 3) sc[pick]++;
      if (go && who == 2'b01 && sc[1 - pick] < 3) sc[1 - pick]++;
      done = (sc[0] == WINS) || (sc[1] == WINS);
      do_round(r, m0, m1, v0, v1, len, go, who, (pick == 1) ? 2'b10 : 2'b01,
               2'(sc[0]), 2'(sc[1]), done);
      m_prio = 1 - pick;
      if (done) begin
        sc[0] = 0; sc[1] = 0;
      end
    end

    // mid-round mode change is ignored; async reset mid-RUN clears everything
    reset_dut();
    do_round(2'b01, 2'b00, 2'b00, 5'd3, 5'd0, 2, 1, 2'b10, 2'b01, 2'd1, 2'd0, 0);
    req = 2'b01; p0_mode = 2'b11; p0_init_val = 5'd9;
    @(negedge clk);
    chk("mid_load_mode", cnt_mode, 2'b11);
    req = 2'b00; p0_mode = 2'b00;
    @(negedge clk);
    chk("mid_run_mode0", cnt_mode, 2'b11);
    @(negedge clk);
    chk("mid_run_mode1", cnt_mode, 2'b11);
    chk("mid_run_s0", score0, 1);
    #2 rst = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_tmo", round_timeout, 0);
    chk("post_rst_state", state_dbg, ST_IDLE);
    do_round(2'b11, 2'b10, 2'b01, 5'd4, 5'd6, 3, 1, 2'b01, 2'b01, 2'd0, 2'd1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_game_scheduler.md
# counter_game_scheduler

Round scheduler and arbiter that shares one multi-mode counter between two player requesters. It grants the counter to one player per round in round-robin order and loads that player's initial value and counting mode. It watches the counter's game-over result, keeps a per-player score and declares a match winner. It sits directly above the multi-mode counter and drives its mode, init and initial-value inputs.

## Interface
- DATA_W, 5, width of counter value / initial value
- SCORE_W, 2, width of each player score
- WINS_TO_MATCH, 3, round wins that end the match (must be ≤ 2^SCORE_W − 1)
- ROUND_TIMEOUT, 64, maximum RUN cycles per round before abort (≥ 2)
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous active-low reset
- req  in  2  per-player round request, bit i = player i
- p0_mode, p1_mode  in  2 each  requested counting mode (00 up1, 01 up2, 10 down1, 11 down2)
- p0_init_val, p1_init_val  in  DATA_W each  requested starting value
- cnt_gameover  in  1  counter game-over pulse
- cnt_who  in  2  counter result, valid with cnt_gameover (10 = max-count side won, 01 = zero-count side won)
- cnt_mode  out  2  mode driven to counter
- cnt_init  out  1  load strobe to counter
- cnt_init_val  out  DATA_W  value driven to counter
- grant  out  2  one-hot owner of current round, 00 when none
- busy  out  1  high in LOAD, RUN and SETTLE
- score0, score1  out  SCORE_W each  round wins per player
- round_timeout  out  1  one-cycle pulse on round abort
- match_over  out  1  high while in DONE
- match_winner  out  2  one-hot match winner, valid while match_over is high

## Operation
- States: IDLE, LOAD, RUN, SETTLE, DONE.
- IDLE: if req ≠ 00, the round-robin pick goes to LOAD. When both players request, the player not granted last wins. After reset, player 0 has priority.
- Grant capture: the winner's mode and init_val are latched at the IDLE→LOAD transition and held for the whole round. Later changes on p*_mode and p*_init_val are ignored.
- LOAD, exactly 1 cycle: cnt_init=1, cnt_init_val=latched value, cnt_mode=latched mode. Always goes to RUN.
- RUN: cnt_init=0, cnt_mode=latched mode, round timer increments each cycle.
  - cnt_gameover with cnt_who=10: the granted player scores +1.
  - cnt_gameover with cnt_who=01: the opponent scores +1.
  - cnt_gameover with cnt_who of 00 or 11: no score change.
  - Any cnt_gameover goes to SETTLE.
  - Timer = ROUND_TIMEOUT−1 with no cnt_gameover: pulse round_timeout, no score change, go to SETTLE.
- SETTLE, 1 cycle: grant is held. The round-robin pointer moves to the other player. If either score now equals WINS_TO_MATCH, go to DONE, else go to IDLE.
- DONE: match_over=1 and match_winner=one-hot of the player at WINS_TO_MATCH. Scores are held and req is ignored. Leave DONE only after req=00 for one full cycle; then clear both scores and go to IDLE.
- Scores saturate at 2^SCORE_W−1. They are never incremented outside RUN.
- Outside LOAD and RUN: cnt_mode=00, cnt_init=0, cnt_init_val=0.

## Timing
- Reset values: state IDLE, grant 00, busy 0, cnt_init 0, cnt_mode 00, cnt_init_val 0, scores 0, round_timeout 0, match_over 0, match_winner 00, RR pointer → player 0.
- Reset is asynchronous and active-low. Asserting it mid-round aborts the round immediately, with no score update and no timeout pulse.
- All outputs are registered.
  - req sampled at edge N: grant and cnt_init are high from edge N+1, for one cycle in LOAD.
  - RUN begins at edge N+2.
- cnt_gameover and the timeout condition in the same cycle: cnt_gameover takes precedence and no timeout pulse is issued.
- Back-to-back rounds: the minimum gap from SETTLE to the next LOAD is 1 IDLE cycle.
- The round timer resets to 0 on entry to RUN. A round lasts at most ROUND_TIMEOUT RUN cycles.

## Structure
- Shared package counter_game_pkg holds:
  - mode encodings COUNT_UP_BY_1 / COUNT_UP_BY_2 / COUNT_DOWN_BY_1 / COUNT_DOWN_BY_2
  - who encodings WHO_MAX (10) / WHO_ZERO (01)
  - the sched_state_t enum
- One sub-module, rr_arbiter2: 2-request round-robin picker with a pointer-advance input and a one-hot grant output.
- FSM, timer, capture registers and score logic live in counter_game_scheduler.

## Test plan
The bench stubs the counter and drives cnt_gameover and cnt_who directly.
- Reset, then req=01, p0_mode=01, p0_init_val=10 -> one cycle with cnt_init=1, cnt_init_val=10, cnt_mode=01, grant=01; then RUN with cnt_mode held at 01.
- req=11 held across 4 rounds, each ended by cnt_gameover -> grants alternate 01, 10, 01, 10.
- Player 0 granted, cnt_who=10 pulses on 3 consecutive rounds -> score0 steps 1, 2, 3; DONE with match_winner=01; after req=00 for 1 cycle, scores clear and state is IDLE.
- Player 1 granted, cnt_who=01 -> score0 increments, score1 unchanged.
- No cnt_gameover for 64 RUN cycles -> round_timeout pulses for exactly 1 cycle, scores unchanged. A second variant asserts cnt_gameover on cycle 64 -> score updates and no timeout pulse.
- rst pulsed low mid-RUN, and p0_mode changed mid-round in a separate run -> all outputs return to reset values immediately; the mode change has no effect on cnt_mode.
